// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared constants and state type for the immediate operand encoder
package exe_pkg;

    localparam int WORD_W          = 32;
    localparam int ROT_STEPS       = 16;
    localparam int SHIFT_OPERAND_W = 12;
    localparam int IMM8_W          = 8;
    localparam int ROT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

endpackage

// File: rtl/rotate_left_even.sv
// rtl/rotate_left_even.sv - combinational rotate-left by twice a 4-bit amount
module rotate_left_even
    import exe_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [ROT_W-1:0]  rot,
    output logic [WORD_W-1:0] rotated
);

    logic [2*WORD_W-1:0] doubled;

    // Shifting a doubled copy left leaves the wrapped-around bits in the upper half,
    // so the upper half is the rotated word; this undoes the decoder's rotate-right.
    always_comb begin
        doubled = {data, data} << {rot, 1'b0};
        rotated = doubled[2*WORD_W-1:WORD_W];
    end

endmodule

// File: rtl/imm_operand_encoder.sv
// rtl/imm_operand_encoder.sv - searches for the rotated-immediate or 12-bit offset encoding of a constant
module imm_operand_encoder #(
    parameter int WORD_W    = 32,
    parameter int ROT_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_store,
    input  logic [WORD_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              encodable,
    output logic [11:0]       shift_operand
);

    import exe_pkg::*;

    enc_state_t                 state, state_next;
    logic [ROT_W-1:0]           rot_cnt;
    logic [WORD_W-1:0]          value_q;
    logic                       ls_q;
    logic [WORD_W-1:0]          rotated;
    logic                       hit;
    logic                       last_rot;
    logic                       accept;
    logic                       load_result;
    logic                       enc_next;
    logic [SHIFT_OPERAND_W-1:0] so_next;

    rotate_left_even u_rot (
        .data    (value_q),
        .rot     (rot_cnt),
        .rotated (rotated)
    );

    assign hit      = (rotated[WORD_W-1:IMM8_W] == '0);
    assign last_rot = (rot_cnt == ROT_W'(ROT_STEPS - 1));
    assign busy     = (state == SEARCH);
    assign done     = (state == DONE);

    // Next state, request acceptance, and the result to latch when the search resolves.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        load_result = 1'b0;
        enc_next    = 1'b0;
        so_next     = '0;
        case (state)
            IDLE, DONE: begin
                accept     = start;
                state_next = start ? SEARCH : IDLE;
            end
            SEARCH: begin
                if (ls_q || hit || last_rot) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (ls_q) begin
            enc_next = (value_q[WORD_W-1:SHIFT_OPERAND_W] == '0);
            so_next  = enc_next ? value_q[SHIFT_OPERAND_W-1:0] : '0;
        end else if (hit) begin
            enc_next = 1'b1;
            so_next  = {rot_cnt, rotated[IMM8_W-1:0]};
        end
    end

    // State, captured request, rotation counter and held result fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rot_cnt       <= '0;
            value_q       <= '0;
            ls_q          <= 1'b0;
            encodable     <= 1'b0;
            shift_operand <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                value_q <= value;
                ls_q    <= load_store;
                rot_cnt <= '0;
            end else if (state == SEARCH && !ls_q && !hit && !last_rot) begin
                rot_cnt <= rot_cnt + 1'b1;
            end
            if (load_result) begin
                encodable     <= enc_next;
                shift_operand <= so_next;
            end
        end
    end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// tb/tb_imm_operand_encoder.sv - directed self-checking bench for imm_operand_encoder
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_store;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        encodable;
    logic [11:0] shift_operand;

    int checks = 0;
    int fails  = 0;

    imm_operand_encoder #(.WORD_W(32), .ROT_STEPS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_store    (load_store),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .encodable     (encodable),
        .shift_operand (shift_operand)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
        end
    endtask

    // Reference Val2 decode: immed_8 rotated right by 2*rotate_imm.
    function automatic logic [31:0] val2_decode(input logic [11:0] so);
        logic [63:0] d;
        d = {24'h0, so[7:0], 24'h0, so[7:0]} >> {so[11:8], 1'b0};
        return d[31:0];
    endfunction

    task automatic issue(input logic [31:0] v, input logic ls);
        @(negedge clk);
        value      = v;
        load_store = ls;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic run(input string tag, input logic [31:0] v, input logic ls,
                       input int exp_n, input logic exp_enc, input logic [11:0] exp_so);
        int n;
        issue(v, ls);
        if (!ls) check(tag, "busy_start", 32'(busy), 32'd1);
        wait_done(n);
        check(tag, "latency", n, exp_n);
        check(tag, "done", 32'(done), 32'd1);
        check(tag, "busy_done", 32'(busy), 32'd0);
        check(tag, "encodable", 32'(encodable), 32'(exp_enc));
        check(tag, "shift_operand", 32'(shift_operand), 32'(exp_so));
    endtask

    initial begin
        int n;
        int extra;
        int done_seen;
        rst        = 1'b1;
        start      = 1'b0;
        load_store = 1'b0;
        value      = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "busy", 32'(busy), 32'd0);
        check("reset", "done", 32'(done), 32'd0);
        check("reset", "encodable", 32'(encodable), 32'd0);
        check("reset", "shift_operand", 32'(shift_operand), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("imm_ff",       32'h0000_00FF, 1'b0,  1, 1'b1, 12'h0FF);
        run("imm_3fc0",     32'h0000_3FC0, 1'b0, 14, 1'b1, 12'hDFF);
        check("imm_3fc0", "val2", val2_decode(shift_operand), 32'h0000_3FC0);
        run("imm_f00f",     32'hF000_000F, 1'b0,  3, 1'b1, 12'h2FF);
        run("imm_zero",     32'h0000_0000, 1'b0,  1, 1'b1, 12'h000);
        run("imm_ff000000", 32'hFF00_0000, 1'b0,  5, 1'b1, 12'h4FF);
        run("imm_101",      32'h0000_0101, 1'b0, 16, 1'b0, 12'h000);
        run("ls_385",       32'h0000_0385, 1'b1,  1, 1'b1, 12'h385);
        run("ls_1000",      32'h0000_1000, 1'b1,  1, 1'b0, 12'h000);
        run("ls_fff",       32'h0000_0FFF, 1'b1,  1, 1'b1, 12'hFFF);

        // A start while busy must be ignored and must not disturb the captured value.
        issue(32'h0000_0101, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        value      = 32'h0000_00FF;
        load_store = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ignore", "latency", 3 + n, 16);
        check("ignore", "done", 32'(done), 32'd1);
        check("ignore", "encodable", 32'(encodable), 32'd0);
        check("ignore", "shift_operand", 32'(shift_operand), 32'd0);

        // Back-to-back request raised during the DONE cycle.
        value = 32'hF000_000F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b", "busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b", "latency", n, 3);
        check("b2b", "encodable", 32'(encodable), 32'd1);
        check("b2b", "shift_operand", 32'(shift_operand), 32'h2FF);

        // Reset in the middle of a search aborts it without a done pulse.
        issue(32'h0000_0101, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort", "busy", 32'(busy), 32'd0);
        check("abort", "done", 32'(done), 32'd0);
        check("abort", "encodable", 32'(encodable), 32'd0);
        check("abort", "shift_operand", 32'(shift_operand), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            extra = done ? 1 : 0;
            done_seen += extra;
        end
        check("abort", "done_pulses", done_seen, 0);
        run("post_abort", 32'h0000_3FC0, 1'b0, 14, 1'b1, 12'hDFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imm_operand_encoder.md
Name: imm_operand_encoder

Overview:
- Inverse of the EXE-stage Val2 immediate decode: takes a 32-bit constant and searches for the ARM shifter-operand encoding {rotate_imm[3:0], immed_8[7:0]} such that immed_8 ROR (2*rotate_imm) equals the constant.
- In load/store mode it encodes a 12-bit unsigned offset instead.
- Multi-cycle, one rotation tested per clock, start/done handshake.
- Used by the assembler-assist/self-test path to generate instruction fields and to cross-check the Val2 decoder.

Parameters:
- WORD_W, 32, operand width (fixed 32; generics for lint only)
- ROT_STEPS, 16, number of rotate_imm values searched (0..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- load_store  input  1  1 = 12-bit offset encoding, 0 = rotated-immediate encoding
- value  input  32  constant to encode; captured on accepted start
- busy  output  1  search in progress
- done  output  1  one-cycle pulse, result fields valid
- encodable  output  1  1 = encoding found; held until next accepted start
- shift_operand  output  12  encoding result; 0 when encodable=0; held until next accepted start

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, busy=0, done=0, encodable=0, shift_operand=0, rotation counter=0, captured value=0.
- Reset wins over every other input at the same edge, including in the middle of a search; no done is produced for an aborted request.
- States: IDLE, SEARCH, DONE.
- IDLE/DONE, start=1 at edge E0:
  - capture value and load_store; counter=0.
  - load_store=1: go to DONE at E0+1.
  - load_store=0: go to SEARCH; busy=1 from E0.
- SEARCH, counter=r:
  - combinationally rotate the captured value left by 2r.
  - if bits [31:8] are zero: hit. At the next edge go to DONE with encodable=1 and shift_operand={r[3:0], rotated[7:0]}.
  - otherwise, r<15: counter increments.
  - otherwise, r=15: go to DONE with encodable=0 and shift_operand=0.
- Smallest r wins, so the encoding is unique and deterministic. value=0 encodes as 0x000 at r=0.
- Load/store mode:
  - encodable = (value[31:12]==0).
  - shift_operand = value[11:0] if encodable, else 0.
  - no rotation search.
- Latency (done high during the cycle after the stated edge):
  - hit at r: after edge E0+r+1, so 1..16 edges.
  - miss: after edge E0+16.
  - load/store: after edge E0+1.
- DONE lasts exactly one cycle; done=1 only in DONE; busy=0 in DONE. The next edge returns to IDLE, or starts a new request if start=1 (back-to-back supported).
- start while busy=1 is ignored; the captured value is unaffected by later changes on value.
- Result outputs change only at the edge entering DONE, or on reset.

Decomposition:
- Shared package (exe_pkg):
  - state enum IDLE/SEARCH/DONE
  - ROT_STEPS, WORD_W
  - SHIFT_OPERAND_W=12, IMM8_W=8, ROT_W=4
- Natural sub-module: rotate_left_even, a combinational 32-bit rotate-left by 2*rot[3:0]. It mirrors the decoder's rotate-right and is reusable by the bench as a reference model.

Test Plan:
- value=0x000000FF, load_store=0, start 1 cycle -> done after E0+1, encodable=1, shift_operand=0x0FF, busy high for 1 cycle.
- value=0x00003FC0 -> hit at r=13, done after E0+14, shift_operand=0xDFF; feeding 0xDFF to the Val2 decoder returns 0x00003FC0.
- value=0xF000000F -> r=2, shift_operand=0x2FF. value=0x00000101 -> done after E0+16, encodable=0, shift_operand=0.
- load_store=1:
  - value=0x00000385 -> done after E0+1, shift_operand=0x385, encodable=1.
  - value=0x00001000 -> encodable=0, shift_operand=0.
- Pulse start with value=0x101, then pulse start again at E0+3 with value=0xFF -> second start ignored; the first result (miss) arrives after E0+16. Then a back-to-back start in the DONE cycle is accepted.
- Assert rst at E0+5 of a 0x101 search -> all outputs 0 next cycle, no done pulse. A new start afterwards completes normally.
